// File: rtl/rv_dm_uart_tx.sv
// rv_dm_uart_tx -- memory-mapped 8N1 console transmitter on the rv_cpu
// data-memory port.
//
// Register window (BASE_ADDR, 16 bytes, word offsets):
//   0x0 TXDATA  W   store with select[0]=1 pushes data[7:0] into the TX FIFO
//   0x4 STATUS  R   {16'h0, level[7:0], 5'h0, empty, full, busy}
//   0x8 CTRL    RW  {15'h0, irq_en, div[15:0]}, bytes 0..2 gated by selects
//   0xC         reserved (reads 0, writes acknowledged and ignored)
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   dm_addr_i             CPU data address; dm_addr_i[31:4] selects the window
//   dm_data_s_i           store data
//   dm_data_select_i      byte enables
//   dm_store_i/dm_load_i  requests, held until acknowledged
//   dm_data_l_o           load data, valid while dm_load_done_o
//   dm_store_done_o       one-cycle store acknowledge
//   dm_load_done_o        one-cycle load acknowledge
//   txd_o                 serial output, idle high
//   irq_o                 level interrupt: irq_en & FIFO empty & transmitter idle
module rv_dm_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic        txd_o,
    output logic        irq_o
);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] LVL_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          state_q, state_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     level_q;
    logic [15:0]     div_q;
    logic            irq_en_q;
    logic [15:0]     timer_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic [1:0]      rd_off_q;

    logic            hit, full, empty, busy;
    logic            st_acc, ld_acc, push, pop, tdone, txd_d, irq_d;
    logic [1:0]      off;
    logic [7:0]      lvl8;
    logic            unused_bits;

    assign unused_bits = ^{dm_addr_i[1:0], dm_data_s_i[31:24], dm_data_select_i[3]};

    assign hit   = (dm_addr_i[31:4] == BASE_ADDR[31:4]);
    assign off   = dm_addr_i[3:2];
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign busy  = (state_q != S_IDLE);
    assign lvl8  = 8'(level_q);
    assign tdone = (timer_q == 16'd0);

    // A push-bearing TXDATA store stalls on the registered full flag, so a
    // pop in the same cycle never lets the push through. Gating on the
    // pending acknowledge keeps a held request from being taken twice.
    assign st_acc = dm_store_i & hit & ~dm_store_done_o &
                    ~((off == 2'd0) & dm_data_select_i[0] & full);
    // Store wins a simultaneous request; the load is taken next cycle.
    assign ld_acc = dm_load_i & hit & ~dm_load_done_o & ~st_acc;
    assign push   = st_acc & (off == 2'd0) & dm_data_select_i[0];

    // ---------------- bus side ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dm_store_done_o <= 1'b0;
            dm_load_done_o  <= 1'b0;
            rd_off_q        <= 2'd0;
            div_q           <= DEFAULT_DIV;
            irq_en_q        <= 1'b0;
        end else begin
            dm_store_done_o <= st_acc;
            dm_load_done_o  <= ld_acc;
            if (ld_acc) rd_off_q <= off;
            if (st_acc && off == 2'd2) begin
                if (dm_data_select_i[0]) div_q[7:0]  <= dm_data_s_i[7:0];
                if (dm_data_select_i[1]) div_q[15:8] <= dm_data_s_i[15:8];
                if (dm_data_select_i[2]) irq_en_q    <= dm_data_s_i[16];
            end
        end
    end

    // Read mux is driven from live state so STATUS reflects the sampling edge.
    always_comb begin
        dm_data_l_o = 32'h0;
        if (dm_load_done_o) begin
            case (rd_off_q)
                2'd1:    dm_data_l_o = {16'h0, lvl8, 5'h0, empty, full, busy};
                2'd2:    dm_data_l_o = {15'h0, irq_en_q, div_q};
                default: dm_data_l_o = 32'h0;
            endcase
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= dm_data_s_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------- transmit FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_START;
            S_START: if (tdone) state_d = S_DATA;
            S_DATA:  if (tdone && bit_cnt_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (tdone) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop   = (state_q == S_IDLE) & ~empty;
        irq_d = irq_en_q & empty & (state_q == S_IDLE);
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shreg_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Bit timer counts DIV..0 and is reloaded from div_q at each bit
    // boundary, so a CTRL write only affects the following bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q   <= 16'd0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'd0;
        end else if (pop) begin
            shreg_q   <= fifo_mem[rd_ptr_q];
            timer_q   <= div_q;
            bit_cnt_q <= 3'd0;
        end else if (state_q != S_IDLE) begin
            if (tdone) begin
                timer_q <= div_q;
                if (state_q == S_DATA) begin
                    shreg_q   <= {1'b0, shreg_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end else begin
                timer_q <= timer_q - 16'd1;
            end
        end
    end

    // Registered line and interrupt; reset forces the line idle at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txd_o <= 1'b1;
            irq_o <= 1'b0;
        end else begin
            txd_o <= txd_d;
            irq_o <= irq_d;
        end
    end
endmodule

// File: tb/tb_rv_dm_uart_tx.sv
module tb_rv_dm_uart_tx;
    localparam logic [31:0] A_TX = 32'h0010_0000;
    localparam logic [31:0] A_ST = 32'h0010_0004;
    localparam logic [31:0] A_CT = 32'h0010_0008;
    localparam logic [31:0] A_RS = 32'h0010_000C;
    localparam int HN = 8192;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] dm_addr_i, dm_data_s_i, dm_data_l_o;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i, dm_load_i, dm_store_done_o, dm_load_done_o, txd_o, irq_o;

    rv_dm_uart_tx dut (
        .clk_i(clk_i), .rst_i(rst_i), .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
        .dm_data_select_i(dm_data_select_i), .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
        .dm_data_l_o(dm_data_l_o), .dm_store_done_o(dm_store_done_o),
        .dm_load_done_o(dm_load_done_o), .txd_o(txd_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, failures = 0;
    int cyc = 0;                      // number of rising edges so far
    always @(posedge clk_i) cyc <= cyc + 1;

    // Line and interrupt history indexed by "state after edge c".
    logic txd_h [HN];
    logic irq_h [HN];
    always @(negedge clk_i) if (cyc < HN) begin txd_h[cyc] = txd_o; irq_h[cyc] = irq_o; end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    // Frame receiver: decodes 8N1 at mon_div, checks each bit is flat for
    // the whole period and the stop bit is high.
    logic       mon_en = 1'b0;
    int         mon_div = 0;
    logic       txd_last = 1'b1;
    logic [9:0] mbits;
    logic       mstable;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         rx_cyc[$];

    always begin
        @(negedge clk_i);
        if (mon_en && txd_last && !txd_o) begin
            rx_cyc.push_back(cyc);
            mstable = 1'b1;
            for (int b = 0; b < 10; b++)
                for (int k = 0; k <= mon_div; k++) begin
                    if (b != 0 || k != 0) @(negedge clk_i);
                    if (k == 0) mbits[b] = txd_o;
                    else if (txd_o !== mbits[b]) mstable = 1'b0;
                end
            chk("frame_shape", {29'h0, mstable, mbits[9], mbits[0]}, 32'h6);
            rx_q.push_back(mbits[8:1]);
        end
        txd_last = txd_o;
    end

    // Store: returns the edge at which it was accepted (-1 on timeout).
    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel,
                      output int acc);
        dm_addr_i = a; dm_data_s_i = d; dm_data_select_i = sel; dm_store_i = 1'b1;
        acc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (dm_store_done_o) begin acc = cyc; break; end
        end
        if (acc < 0) chk("store_timeout", {31'h0, dm_store_done_o}, 32'h1);
        @(posedge clk_i); #1;
        dm_store_i = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, output logic [31:0] d);
        dm_addr_i = a; dm_load_i = 1'b1; d = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (dm_load_done_o) begin d = dm_data_l_o; break; end
        end
        dm_load_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin @(posedge clk_i); #1; end
    endtask

    logic [15:0] m_div;
    logic        m_en;
    task automatic ctrl_wr(input logic [31:0] d, input logic [3:0] sel, output int acc);
        st(A_CT, d, sel, acc);
        if (sel[0]) m_div[7:0]  = d[7:0];
        if (sel[1]) m_div[15:8] = d[15:8];
        if (sel[2]) m_en        = d[16];
    endtask

    task automatic tx(input logic [7:0] b, output int acc);
        st(A_TX, {24'h0, b}, 4'h1, acc);
        exp_q.push_back(b);
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < 20000 && rx_q.size() < n; i++) begin @(posedge clk_i); #1; end
        chk("drain_cnt", rx_q.size(), n);
        while (exp_q.size() > 0 && rx_q.size() > 0) chk("rx_byte", rx_q.pop_front(), exp_q.pop_front());
        exp_q.delete(); rx_q.delete();
        repeat (3) begin @(posedge clk_i); #1; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int acc, w, bad, d, n, seen;
        int a[10];

        rst_i = 1'b1; dm_addr_i = 0; dm_data_s_i = 0; dm_data_select_i = 0;
        dm_store_i = 0; dm_load_i = 0;
        m_div = 16'd867; m_en = 1'b0;
        repeat (2) @(posedge clk_i); #1;
        chk("rst_txd", {31'h0, txd_o}, 1);
        chk("rst_irq", {31'h0, irq_o}, 0);
        chk("rst_done", {30'h0, dm_store_done_o, dm_load_done_o}, 0);
        chk("rst_ldata", dm_data_l_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        ld(A_ST, rd); chk("status_rst", rd, 32'h4);
        ld(A_CT, rd); chk("ctrl_rst", rd, 32'h363);
        ld(A_TX, rd); chk("txdata_rd0", rd, 0);
        ld(A_RS, rd); chk("resv_rd0", rd, 0);

        // Misses are never acknowledged.
        dm_addr_i = 32'h0020_0000; dm_store_i = 1; dm_data_select_i = 4'hF; seen = 0;
        repeat (20) begin @(negedge clk_i); if (dm_store_done_o) seen++; end
        dm_store_i = 0; dm_load_i = 1;
        repeat (20) begin @(negedge clk_i); if (dm_load_done_o) seen++; end
        dm_load_i = 0; @(posedge clk_i); #1;
        chk("miss_noack", seen, 0);

        // Writes to read-only / reserved offsets and select[0]=0 TXDATA: no effect.
        st(A_ST, 32'hFFFF_FFFF, 4'hF, acc);
        st(A_RS, 32'hFFFF_FFFF, 4'hF, acc);
        st(A_TX, 32'h0000_00AA, 4'hE, acc);
        ld(A_ST, rd); chk("ro_noeffect", rd, 32'h4);

        // Single frame, DIV=3: exact waveform and busy window.
        mon_en = 1; mon_div = 3; rx_cyc.delete();
        ctrl_wr(32'h3, 4'hF, w);
        ld(A_CT, rd); chk("ctrl_rb", rd, 32'h3);
        tx(8'h55, acc);
        wait_cyc(acc + 39);
        ld(A_ST, rd); chk("busy_last", rd, 32'h5);
        wait_cyc(acc + 46);
        bad = 0;
        for (int c = acc + 1; c <= acc + 44; c++)
            if (txd_h[c] !== ((c < acc + 2 || c >= acc + 42) ? 1'b1 : fbit(8'h55, (c - acc - 2) / 4))) bad++;
        chk("wave_55", bad, 0);
        chk("fall_lat", rx_cyc[0] - acc, 2);
        ld(A_ST, rd); chk("status_idle", rd, 32'h4);
        drain();

        // Fill the FIFO at DIV=3: 10th store stalls until the second pop.
        rx_cyc.delete();
        for (int i = 0; i < 10; i++) begin b = 8'($urandom); tx(b, a[i]); end
        chk("fill_no_stall", a[8] - a[0], 16);
        chk("stall_acc", a[9] - a[0], 43);
        drain();
        bad = 0;
        for (int i = 1; i < rx_cyc.size(); i++) if (rx_cyc[i] - rx_cyc[i-1] != 41) bad++;
        chk("gap_d3", bad, 0);
        chk("nframes_d3", rx_cyc.size(), 10);

        // DIV=0, 9 bytes back to back: 11-cycle frame spacing.
        ctrl_wr(32'h0, 4'hF, w); mon_div = 0; rx_cyc.delete();
        for (int i = 0; i < 9; i++) begin b = 8'(i + 1); tx(b, a[i]); end
        drain();
        bad = 0;
        for (int i = 1; i < rx_cyc.size(); i++) if (rx_cyc[i] - rx_cyc[i-1] != 11) bad++;
        chk("gap_d0", bad, 0);
        chk("nframes_d0", rx_cyc.size(), 9);

        // Interrupt.
        ctrl_wr(32'h0001_0002, 4'hF, w); mon_div = 2;
        tx(8'hA5, acc);
        wait_cyc(acc + 30);
        ld(A_ST, rd); chk("idle_after_frame", rd, 32'h4);
        wait_cyc(acc + 36);
        chk("irq_idle_en", {31'h0, irq_h[w + 1]}, 1);
        bad = 0;
        for (int c = acc + 1; c <= acc + 31; c++) if (irq_h[c] !== 1'b0) bad++;
        chk("irq_low_sending", bad, 0);
        chk("irq_rise", {31'h0, irq_h[acc + 32]}, 1);
        ctrl_wr(32'h2, 4'hF, w);
        @(posedge clk_i); #1;
        chk("irq_before_clr", {31'h0, irq_h[w]}, 1);
        chk("irq_clr", {31'h0, irq_h[w + 1]}, 0);
        drain();

        // Mid-frame divisor change 3 -> 1.
        ctrl_wr(32'h3, 4'hF, w);
        mon_en = 0;
        b = 8'($urandom);
        st(A_TX, {24'h0, b}, 4'h1, acc);
        wait_cyc(acc + 2);
        ctrl_wr(32'h1, 4'h1, w);
        chk("middiv_wr_edge", w - acc, 3);
        wait_cyc(acc + 30);
        bad = 0;
        for (int c = acc + 1; c <= acc + 27; c++) begin
            logic e;
            if (c < acc + 2 || c >= acc + 24) e = 1'b1;
            else if (c < acc + 6) e = 1'b0;
            else e = fbit(b, 1 + (c - acc - 6) / 2);
            if (txd_h[c] !== e) bad++;
        end
        chk("middiv_wave", bad, 0);
        mon_en = 1;

        // Randomized: CTRL byte-enable readback, then random bursts.
        for (int i = 0; i < 4; i++) begin
            ctrl_wr($urandom, 4'($urandom_range(0, 15)), w);
            ld(A_CT, rd); chk("ctrl_rand", rd, {15'h0, m_en, m_div});
        end
        for (int r = 0; r < 3; r++) begin
            d = $urandom_range(0, 2); n = $urandom_range(1, 12);
            ctrl_wr(d, 4'hF, w); mon_div = d;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) st(A_TX, $urandom, 4'hE, acc);
                b = 8'($urandom); tx(b, acc);
            end
            drain();
        end

        // Reset in the middle of a 3-byte burst.
        ctrl_wr(32'h3, 4'hF, w); mon_en = 0;
        st(A_TX, 32'h00, 4'h1, a[0]);
        st(A_TX, 32'h3C, 4'h1, acc);
        st(A_TX, 32'hFF, 4'h1, acc);
        wait_cyc(a[0] + 10);
        @(negedge clk_i);
        chk("pre_rst_low", {31'h0, txd_o}, 0);
        #2 rst_i = 1'b1;
        #1 chk("rst_async_txd", {31'h0, txd_o}, 1);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0; m_div = 16'd867; m_en = 1'b0;
        ld(A_ST, rd); chk("status_after_rst", rd, 32'h4);
        ld(A_CT, rd); chk("ctrl_after_rst", rd, 32'h363);
        seen = 0;
        repeat (300) begin @(negedge clk_i); if (txd_o !== 1'b1) seen++; end
        chk("no_frames_after_rst", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
